sound_sequencer: RTL

Priority scheduler for the piezo tone generator. It accepts sound-effect requests from the game logic (move click, food eaten, game over) and arbitrates between them by fixed priority. It sequences the winning effect's notes from an internal effect ROM and drives the tone generator's phase-step (`tone_step`) and enable, so that only one effect owns the speaker at a time.

---
 rtl/sound_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sound_sequencer.sv
// ============================================================================
//  sound_sequencer : fixed-priority sound-effect scheduler for the piezo tone
//                    generator; plays one ROM effect at a time.
//  Revision 1.0
// ============================================================================
`default_nettype none

module sound_sequencer #(
  parameter int unsigned TICK_DIV = 2097152,
  parameter int unsigned STEP_W   = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req,
  output logic [STEP_W-1:0] tone_step,
  output logic              tone_en,
  output logic              busy,
  output logic [1:0]        active_id,
  output logic              done
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] c_slot_last = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [2:0]          r_pending, w_pending_nxt, w_clr;
  logic [3:0]          r_ptr, w_ptr_nxt;
  logic [2:0]          r_slots_left, w_slots_nxt;
  logic [CNT_W-1:0]    r_slot_cnt, w_cnt_nxt;
  logic [STEP_W-1:0]   w_step_nxt;
  logic                w_en_nxt, w_busy_nxt, w_done_nxt;
  logic [1:0]          w_id_nxt;

  logic [8:0]          w_rom;
  logic [STEP_W-1:0]   w_rom_step;
  logic [2:0]          w_rom_slots;
  logic [2:0]          w_higher;

  // ROM word = {step[5:0], slots[2:0]}; slots == 0 marks the end of an effect.
  function automatic logic [8:0] rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_word = {6'd25, 3'd1};
      4'd1:    rom_word = {6'd0,  3'd0};
      4'd2:    rom_word = {6'd25, 3'd1};
      4'd3:    rom_word = {6'd31, 3'd1};
      4'd4:    rom_word = {6'd33, 3'd2};
      4'd5:    rom_word = {6'd0,  3'd0};
      4'd6:    rom_word = {6'd21, 3'd2};
      4'd7:    rom_word = {6'd0,  3'd1};
      4'd8:    rom_word = {6'd20, 3'd2};
      4'd9:    rom_word = {6'd0,  3'd1};
      4'd10:   rom_word = {6'd17, 3'd4};
      default: rom_word = {6'd0,  3'd0};
    endcase
  endfunction

  function automatic logic [3:0] rom_base(input logic [1:0] id);
    case (id)
      2'd1:    rom_base = 4'd2;
      2'd2:    rom_base = 4'd6;
      default: rom_base = 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] top_id(input logic [2:0] p);
    if (p[2])      top_id = 2'd2;
    else if (p[1]) top_id = 2'd1;
    else           top_id = 2'd0;
  endfunction

  function automatic logic [2:0] above_mask(input logic [1:0] id);
    case (id)
      2'd0:    above_mask = 3'b110;
      2'd1:    above_mask = 3'b100;
      default: above_mask = 3'b000;
    endcase
  endfunction

  assign w_rom       = rom_word(r_ptr);
  assign w_rom_step  = STEP_W'(w_rom[8:3]);
  assign w_rom_slots = w_rom[2:0];
  assign w_higher    = r_pending & above_mask(active_id);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pending    <= 3'b000;
      r_ptr        <= 4'd0;
      r_slots_left <= 3'd0;
      r_slot_cnt   <= '0;
      tone_step    <= '0;
      tone_en      <= 1'b0;
      busy         <= 1'b0;
      active_id    <= 2'd0;
      done         <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pending    <= w_pending_nxt;
      r_ptr        <= w_ptr_nxt;
      r_slots_left <= w_slots_nxt;
      r_slot_cnt   <= w_cnt_nxt;
      tone_step    <= w_step_nxt;
      tone_en      <= w_en_nxt;
      busy         <= w_busy_nxt;
      active_id    <= w_id_nxt;
      done         <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_slots_nxt = r_slots_left;
    w_cnt_nxt   = r_slot_cnt;
    w_step_nxt  = tone_step;
    w_en_nxt    = tone_en;
    w_id_nxt    = active_id;
    w_done_nxt  = 1'b0;
    w_clr       = 3'b000;

    unique case (r_state)
      S_IDLE: begin
        w_step_nxt = '0;
        w_en_nxt   = 1'b0;
        w_id_nxt   = 2'd0;
        if (|r_pending) begin
          w_id_nxt    = top_id(r_pending);
          w_ptr_nxt   = rom_base(top_id(r_pending));
          w_clr       = 3'b001 << top_id(r_pending);
          w_state_nxt = S_LOAD;
        end
      end

      S_LOAD: begin
        if (w_rom_slots == 3'd0) begin
          w_step_nxt  = '0;
          w_en_nxt    = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_step_nxt  = w_rom_step;
          w_en_nxt    = (w_rom_step != '0);
          w_slots_nxt = w_rom_slots;
          w_cnt_nxt   = '0;
          w_state_nxt = S_PLAY;
        end
      end

      S_PLAY: begin
        if (r_slot_cnt == c_slot_last) begin
          w_cnt_nxt = '0;
          // A higher-priority request abandons the current effect outright.
          if (|w_higher) begin
            w_id_nxt    = top_id(w_higher);
            w_ptr_nxt   = rom_base(top_id(w_higher));
            w_clr       = 3'b001 << top_id(w_higher);
            w_state_nxt = S_LOAD;
          end else if (r_slots_left == 3'd1) begin
            w_ptr_nxt   = r_ptr + 4'd1;
            w_state_nxt = S_LOAD;
          end else begin
            w_slots_nxt = r_slots_left - 3'd1;
          end
        end else begin
          w_cnt_nxt = r_slot_cnt + 1'b1;
        end
      end

      S_DONE: begin
        w_id_nxt    = 2'd0;
        w_state_nxt = S_IDLE;
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // A request arriving in the same cycle as its selection stays pending.
    w_pending_nxt = (r_pending & ~w_clr) | req;
    w_busy_nxt    = (w_state_nxt == S_LOAD) || (w_state_nxt == S_PLAY);
  end

endmodule

`default_nettype wire
